// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch sequencer: machine sizing and the
// sequencer state encoding (the encoding is also shown on the board LEDs).
package fetch_ctrl_pkg;

  localparam int INSTR_ADDR_W = 4;
  localparam int NUM_INSTRS   = 8;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_PAUSE = 2'b01,
    ST_STEP  = 2'b10,
    ST_HALT  = 2'b11
  } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl_btn_sync_edge.sv
// Pushbutton conditioner: 2-flop synchronizer, debounce counter, debounced
// level and a one-cycle pulse on an accepted press (active-low button, so a
// press is an accepted high-to-low change of the debounced level).
module btn_sync_edge #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic i_btn_n,
  output logic o_press_p
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             meta_q, meta_d;
  logic             sync_q, sync_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  // Synchronizer shift and debounce: the level only follows the synchronized
  // input after it has disagreed with it for DEBOUNCE_CYCLES cycles in a row.
  always_comb begin
    meta_d  = i_btn_n;
    sync_d  = meta_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (sync_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q;
        cnt_d   = CNT_ZERO;
        press_d = ~sync_q;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = CNT_ZERO;
    end
  end

  // Conditioner registers; reset means "button not pressed".
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= CNT_ZERO;
      press_q <= 1'b0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign o_press_p = press_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, runs the RUN/PAUSE/STEP/HALT machine
// and drives pipeline enable / IF-ID hold / bubble controls each cycle.
module fetch_ctrl #(
  parameter int INSTR_ADDR_W    = fetch_ctrl_pkg::INSTR_ADDR_W,
  parameter int NUM_INSTRS      = fetch_ctrl_pkg::NUM_INSTRS,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    i_stall_req,
  input  logic                    i_redirect,
  input  logic [INSTR_ADDR_W-1:0] i_redirect_pc,
  input  logic                    i_halt,
  input  logic                    i_run,
  input  logic                    i_step_n,
  output logic [INSTR_ADDR_W-1:0] o_pc,
  output logic                    o_pipe_en,
  output logic                    o_ifid_hold,
  output logic                    o_ifid_bubble,
  output logic                    o_idex_bubble,
  output logic [1:0]              o_state
);

  import fetch_ctrl_pkg::*;

  localparam logic [INSTR_ADDR_W-1:0] PC_ZERO = INSTR_ADDR_W'(0);
  localparam logic [INSTR_ADDR_W-1:0] PC_ONE  = INSTR_ADDR_W'(1);
  localparam logic [INSTR_ADDR_W-1:0] PC_LAST = INSTR_ADDR_W'(NUM_INSTRS - 1);

  fetch_state_t            state_q, state_d;
  logic [INSTR_ADDR_W-1:0] pc_q, pc_d;
  logic                    run_meta_q, run_meta_d;
  logic                    run_s_q, run_s_d;
  logic                    step_p;
  logic                    pipe_en_s, ifid_hold_s, ifid_bubble_s, idex_bubble_s;
  logic                    halt_acc_s;

  btn_sync_edge #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_btn (
    .clock    (clock),
    .reset    (reset),
    .i_btn_n  (i_step_n),
    .o_press_p(step_p)
  );

  // Run switch synchronizer feeding run_s.
  always_comb begin
    run_meta_d = i_run;
    run_s_d    = run_meta_q;
  end

  // Next state, next PC and per-cycle pipeline controls. On an advance cycle
  // redirect beats stall beats halt: a redirect means the instructions in ID
  // are wrong-path, so their stall/halt requests are meaningless.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pipe_en_s     = 1'b0;
    ifid_hold_s   = 1'b0;
    ifid_bubble_s = 1'b0;
    idex_bubble_s = 1'b0;
    halt_acc_s    = 1'b0;
    case (state_q)
      ST_PAUSE: begin
        if (run_s_q) begin
          state_d = ST_RUN;
        end else if (step_p) begin
          state_d = ST_STEP;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      ST_RUN, ST_STEP: begin
        pipe_en_s = 1'b1;
        if (i_redirect) begin
          ifid_bubble_s = 1'b1;
          idex_bubble_s = 1'b1;
          if (i_redirect_pc <= PC_LAST) begin
            pc_d = i_redirect_pc;
          end else begin
            pc_d = PC_ZERO;
          end
        end else if (i_stall_req) begin
          ifid_hold_s   = 1'b1;
          idex_bubble_s = 1'b1;
        end else if (i_halt) begin
          ifid_bubble_s = 1'b1;
          halt_acc_s    = 1'b1;
        end else begin
          if (pc_q == PC_LAST) begin
            pc_d = PC_ZERO;
          end else begin
            pc_d = pc_q + PC_ONE;
          end
        end
        // An accepted halt is final; otherwise a step lasts one cycle and
        // free run ends when the switch goes off.
        if (halt_acc_s) begin
          state_d = ST_HALT;
        end else if ((state_q == ST_STEP) || !run_s_q) begin
          state_d = ST_PAUSE;
        end else begin
          state_d = state_q;
        end
      end
      ST_HALT: begin
        // Keep draining older instructions while fetch stays frozen.
        pipe_en_s     = 1'b1;
        ifid_bubble_s = 1'b1;
      end
      default: begin
        state_d = ST_PAUSE;
      end
    endcase
  end

  // State, PC and run synchronizer registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_PAUSE;
      pc_q       <= PC_ZERO;
      run_meta_q <= 1'b0;
      run_s_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      run_meta_q <= run_meta_d;
      run_s_q    <= run_s_d;
    end
  end

  assign o_pc          = pc_q;
  assign o_state       = state_q;
  assign o_pipe_en     = pipe_en_s;
  assign o_ifid_hold   = ifid_hold_s;
  assign o_ifid_bubble = ifid_bubble_s;
  assign o_idex_bubble = idex_bubble_s;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: a behavioural model (input histories,
// a state number and an integer PC) predicts every output each cycle, and a
// few hand-computed checks pin the directed scenarios.
module tb_fetch_ctrl;

  localparam int AW  = 4;
  localparam int NI  = 8;
  localparam int DEB = 16;

  localparam int S_RUN = 0, S_PAUSE = 1, S_STEP = 2, S_HALT = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          i_stall_req, i_redirect, i_halt, i_run, i_step_n;
  logic [AW-1:0] i_redirect_pc;
  logic [AW-1:0] o_pc;
  logic          o_pipe_en, o_ifid_hold, o_ifid_bubble, o_idex_bubble;
  logic [1:0]    o_state;

  fetch_ctrl #(
    .INSTR_ADDR_W   (AW),
    .NUM_INSTRS     (NI),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .i_stall_req  (i_stall_req),
    .i_redirect   (i_redirect),
    .i_redirect_pc(i_redirect_pc),
    .i_halt       (i_halt),
    .i_run        (i_run),
    .i_step_n     (i_step_n),
    .o_pc         (o_pc),
    .o_pipe_en    (o_pipe_en),
    .o_ifid_hold  (o_ifid_hold),
    .o_ifid_bubble(o_ifid_bubble),
    .o_idex_bubble(o_idex_bubble),
    .o_state      (o_state)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: state number, PC, raw-input histories since reset, debounce level.
  int m_state;
  int m_pc;
  bit m_level;
  bit m_pulse;
  bit run_hist[$];
  bit step_hist[$];

  // Last sampled control outputs (taken mid-cycle by the compare step).
  logic s_ifid_hold, s_ifid_bubble, s_idex_bubble, s_pipe_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = S_PAUSE;
    m_pc    = 0;
    m_level = 1'b1;
    m_pulse = 1'b0;
    run_hist.delete();
    step_hist.delete();
    for (int i = 0; i < 2; i++) run_hist.push_back(1'b0);
    for (int i = 0; i < DEB + 1; i++) step_hist.push_back(1'b1);
  endtask

  // Advance the model across one active clock edge.
  task automatic model_edge();
    bit run_s;
    bit all_differ;
    bit halted;
    if (!reset) return;
    run_s = run_hist[0];
    if (m_state == S_PAUSE) begin
      if (run_s) m_state = S_RUN;
      else if (m_pulse) m_state = S_STEP;
    end else if (m_state == S_RUN || m_state == S_STEP) begin
      halted = 1'b0;
      if (i_redirect) m_pc = (int'(i_redirect_pc) < NI) ? int'(i_redirect_pc) : 0;
      else if (i_stall_req) m_pc = m_pc;
      else if (i_halt) halted = 1'b1;
      else m_pc = (m_pc + 1) % NI;
      if (halted) m_state = S_HALT;
      else if (m_state == S_STEP || !run_s) m_state = S_PAUSE;
    end
    // Debounce: the level flips once the synchronized button has disagreed
    // with it for DEB consecutive samples; a flip to 0 is a press.
    all_differ = 1'b1;
    for (int i = 0; i < DEB; i++) if (step_hist[i] == m_level) all_differ = 1'b0;
    m_pulse = 1'b0;
    if (all_differ) begin
      m_level = ~m_level;
      m_pulse = (m_level == 1'b0);
    end
    void'(run_hist.pop_front());
    run_hist.push_back(i_run);
    void'(step_hist.pop_front());
    step_hist.push_back(i_step_n);
  endtask

  // Compare every DUT output with the model's prediction for this cycle.
  task automatic check_outputs();
    int e_en, e_hold, e_ifb, e_idb;
    e_en = 0; e_hold = 0; e_ifb = 0; e_idb = 0;
    if (m_state == S_HALT) begin
      e_en = 1; e_ifb = 1;
    end else if (m_state != S_PAUSE) begin
      e_en = 1;
      if (i_redirect) begin e_ifb = 1; e_idb = 1; end
      else if (i_stall_req) begin e_hold = 1; e_idb = 1; end
      else if (i_halt) e_ifb = 1;
    end
    chk("pc", 32'(o_pc), 32'(m_pc));
    chk("state", 32'(o_state), 32'(m_state));
    chk("pipe_en", 32'(o_pipe_en), 32'(e_en));
    chk("ifid_hold", 32'(o_ifid_hold), 32'(e_hold));
    chk("ifid_bubble", 32'(o_ifid_bubble), 32'(e_ifb));
    chk("idex_bubble", 32'(o_idex_bubble), 32'(e_idb));
    s_pipe_en = o_pipe_en; s_ifid_hold = o_ifid_hold;
    s_ifid_bubble = o_ifid_bubble; s_idex_bubble = o_idex_bubble;
  endtask

  // One cycle: compare mid-cycle, then advance the model at the edge.
  // Inputs may be changed by the caller once this returns.
  task automatic cycle();
    @(negedge clock);
    #1;
    check_outputs();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic wait_for(input string name, input int st, input int pc, input int bound);
    int n = 0;
    while (!(o_state == 2'(st) && (pc < 0 || o_pc == AW'(pc))) && n < bound) begin
      cycle();
      n++;
    end
    n_tests++;
    if (n >= bound) begin
      n_fail++;
      $display("FAIL %s: timeout, state %0d pc %0d, wanted state %0d pc %0d", name, o_state, o_pc, st, pc);
    end
  endtask

  int steps;

  task automatic hold_step(input logic val, input int n);
    i_step_n = val;
    for (int i = 0; i < n; i++) begin
      cycle();
      if (o_state == 2'(S_STEP)) steps++;
    end
  endtask

  task automatic random_cycles(input int n, input bit allow_halt);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(39, 0) == 0) i_run = ~i_run;
      if ($urandom_range(19, 0) == 0) i_step_n = ~i_step_n;
      i_redirect    = ($urandom_range(5, 0) == 0);
      i_stall_req   = ($urandom_range(4, 0) == 0);
      i_redirect_pc = AW'($urandom_range(15, 0));
      i_halt        = allow_halt && ($urandom_range(3, 0) == 0);
      cycle();
    end
  endtask

  task automatic clear_ctl();
    i_stall_req = 1'b0; i_redirect = 1'b0; i_halt = 1'b0; i_redirect_pc = AW'(0);
  endtask

  int pc0;

  initial begin
    reset = 1'b0; i_run = 1'b0; i_step_n = 1'b1;
    clear_ctl();
    model_reset();
    repeat (3) cycle();
    reset = 1'b1;

    // Idle after reset: paused, PC 0, nothing enabled.
    repeat (12) cycle();
    chk("idle_pc", 32'(o_pc), 32'd0);
    chk("idle_state", 32'(o_state), 32'd1);
    chk("idle_pipe_en", 32'(o_pipe_en), 32'd0);

    // Free run: PC walks 0..7 and wraps.
    i_run = 1'b1;
    wait_for("enter_run", S_RUN, -1, 10);
    for (int i = 0; i < 10; i++) begin
      chk("run_seq_pc", 32'(o_pc), 32'(i % NI));
      cycle();
    end

    // Bouncy step press in PAUSE: exactly one step.
    i_run = 1'b0;
    repeat (6) cycle();
    pc0 = int'(o_pc);
    steps = 0;
    hold_step(1'b0, 3); hold_step(1'b1, 2); hold_step(1'b0, 4);
    hold_step(1'b1, 1); hold_step(1'b0, 2); hold_step(1'b1, 3);
    hold_step(1'b0, 40); hold_step(1'b1, 30);
    chk("step_count", 32'(steps), 32'd1);
    chk("step_pc", 32'(o_pc), 32'((pc0 + 1) % NI));

    // Redirect beats stall; out-of-range redirect target wraps to 0.
    i_run = 1'b1;
    wait_for("reach_pc3", S_RUN, 3, 40);
    i_stall_req = 1'b1; i_redirect = 1'b1; i_redirect_pc = AW'(6);
    cycle();
    chk("redir_ifid_bubble", 32'(s_ifid_bubble), 32'd1);
    chk("redir_idex_bubble", 32'(s_idex_bubble), 32'd1);
    chk("redir_ifid_hold", 32'(s_ifid_hold), 32'd0);
    chk("redir_pc", 32'(o_pc), 32'd6);
    i_stall_req = 1'b0; i_redirect_pc = AW'(9);
    cycle();
    chk("redir_wrap_pc", 32'(o_pc), 32'd0);
    clear_ctl();

    // Random traffic without halts (RUN/PAUSE/STEP mixing).
    random_cycles(400, 1'b0);

    // Halt at pc 5: frozen forever, draining, later redirects ignored.
    clear_ctl();
    i_run = 1'b1; i_step_n = 1'b1;
    wait_for("reach_pc5", S_RUN, 5, 80);
    i_halt = 1'b1;
    cycle();
    chk("halt_ifid_bubble", 32'(s_ifid_bubble), 32'd1);
    chk("halt_state", 32'(o_state), 32'd3);
    chk("halt_pc", 32'(o_pc), 32'd5);
    random_cycles(40, 1'b1);
    chk("halt_pc_frozen", 32'(o_pc), 32'd5);
    chk("halt_pipe_en", 32'(s_pipe_en), 32'd1);

    // Reset mid-RUN at pc 4 aborts at once; RUN resumes only via run_s.
    clear_ctl();
    reset = 1'b0; model_reset();
    repeat (2) cycle();
    reset = 1'b1; i_run = 1'b1; i_step_n = 1'b1;
    wait_for("reach_pc4", S_RUN, 4, 40);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("rst_pc", 32'(o_pc), 32'd0);
    chk("rst_state", 32'(o_state), 32'd1);
    chk("rst_pipe_en", 32'(o_pipe_en), 32'd0);
    repeat (2) cycle();
    reset = 1'b1;
    cycle();
    chk("rst_still_paused", 32'(o_state), 32'd1);
    repeat (4) cycle();
    chk("rst_resumed_run", 32'(o_state), 32'd0);
    random_cycles(200, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Pipeline sequencer that owns the fetch PC and decides, every cycle, whether the pipeline advances. It also decides whether IF/ID loads, holds or takes a bubble, and whether wrong-path instructions are flushed. It sits beside the IF stage and drives the enables of every pipeline register. It arbitrates ID load-use stalls, EX branch redirects and ID halt detection. It also provides board-level run/single-step control from a switch and a pushbutton.

## Interface
Parameters:
- INSTR_ADDR_W, from shared specs: PC width.
- NUM_INSTRS, from shared specs: instruction memory depth. PC wraps to 0 past NUM_INSTRS-1.
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required to accept a step-button change.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low.
- i_stall_req  in  1  ID load-use hazard.
- i_redirect  in  1  EX taken branch/jump.
- i_redirect_pc  in  INSTR_ADDR_W  redirect target.
- i_halt  in  1  ID holds a halt instruction.
- i_run  in  1  raw switch; 1 = free run, 0 = paused/step mode.
- i_step_n  in  1  raw pushbutton, active-low.
- o_pc  out  INSTR_ADDR_W  registered fetch PC.
- o_pipe_en  out  1  global enable for all pipeline registers.
- o_ifid_hold  out  1  IF/ID keeps its value.
- o_ifid_bubble  out  1  IF/ID loads zero (NOP).
- o_idex_bubble  out  1  ID/EX loads zero.
- o_state  out  2  FSM state for LEDs.

## Operation
- States and o_state encodings: RUN=00, PAUSE=01, STEP=10, HALT=11.
- i_run passes through a 2-flop synchronizer, giving run_s.
- i_step_n passes through a 2-flop synchronizer and the debouncer. The result is step_p, a 1-cycle pulse on an accepted press (high-to-low).
- Advance cycle: state is RUN, STEP or HALT. o_pipe_en=1 exactly on advance cycles.
- Transitions:
  - PAUSE to RUN when run_s=1. Otherwise PAUSE to STEP on step_p.
  - STEP to PAUSE after its single advance cycle.
  - RUN to PAUSE when run_s=0.
  - RUN or STEP to HALT when a halt is accepted (see below).
  - HALT is left only by reset.
- Advance-cycle priority: redirect > stall > halt > normal.
  - Redirect:
    - o_pc <= i_redirect_pc, or 0 if i_redirect_pc >= NUM_INSTRS.
    - o_ifid_bubble=1, o_idex_bubble=1.
    - i_halt and i_stall_req are ignored because they come from a wrong-path instruction.
  - Stall:
    - o_pc holds.
    - o_ifid_hold=1.
    - o_idex_bubble=1.
  - Halt (only in RUN or STEP):
    - o_pc holds.
    - o_ifid_bubble=1.
    - Halt is accepted and the next state is HALT.
  - Normal: o_pc <= o_pc+1, or 0 when o_pc == NUM_INSTRS-1.
- HALT behaviour:
  - o_pipe_en stays 1 so older instructions drain.
  - o_pc is frozen.
  - o_ifid_bubble=1 every cycle.
  - i_stall_req, i_redirect and i_halt are ignored.
- Not-advance cycles (PAUSE):
  - All control outputs are 0.
  - o_pc holds.
  - Inputs are ignored.
- Control outputs are combinational from state and inputs. o_pc and state are registered.

## Timing
- Reset (asynchronous):
  - o_pc=0, state=PAUSE.
  - o_pipe_en, o_ifid_hold, o_ifid_bubble and o_idex_bubble are all 0.
  - o_state=01.
  - Synchronizer flops, debounce counter and debounced level reset to "not pressed".
- Run switch: an i_run change appears in run_s 2 cycles later. The state changes on the following edge.
- Step:
  - step_p asserts 2 + DEBOUNCE_CYCLES cycles after a clean press.
  - STEP is active the cycle after step_p, giving exactly one advance per press.
  - A button release generates no pulse.
- A step_p that arrives while in RUN, STEP or HALT is discarded.
- Redirect and normal PC updates take effect on the clock edge ending the advance cycle (PC latency 1).
- Reset mid-operation aborts immediately. No drain occurs.

## Structure
- Shared package/specs header holds:
  - the state enum fetch_state_t (RUN, PAUSE, STEP, HALT with the encodings above);
  - INSTR_ADDR_W and NUM_INSTRS.
- Sub-module btn_sync_edge (parameter DEBOUNCE_CYCLES). It contains the 2-flop synchronizer, the debounce counter, the debounced level and the falling-edge pulse. It is instantiated for i_step_n.
- The i_run synchronizer is inline.

## Test plan
- Reset, then no inputs: o_pc=0, o_state=01, o_pipe_en=0, holding indefinitely.
- Free run with NUM_INSTRS=8, run_s=1: o_pc goes 0,1,…,7,0,1. o_pipe_en=1 and no bubbles.
- Step press that bounces 5 times within DEBOUNCE_CYCLES, then holds 40 cycles, in PAUSE: exactly one STEP cycle and o_pc goes 0 to 1.
- RUN at pc=3 with i_stall_req=1, i_redirect=1, i_redirect_pc=6 in the same cycle: o_ifid_bubble=1, o_idex_bubble=1, o_ifid_hold=0, next o_pc=6. A redirect to 9 with NUM_INSTRS=8 gives next o_pc=0.
- RUN at pc=5 with i_halt=1: next state HALT and o_pc stays 5 forever. o_pipe_en=1 and o_ifid_bubble=1 each cycle. A later i_redirect is ignored.
- Reset asserted mid-RUN at pc=4: o_pc=0 and o_state=01 immediately. After release, RUN resumes only once run_s is seen.
